// File: rtl/bpi_cmd_pkg.sv
// Shared definitions for the BPI flash command sequencer:
// request op codes, CFI command words, FSM states and completion codes.
package bpi_cmd_pkg;

    typedef enum logic [1:0] {
        OP_ERASE   = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_UNLOCK  = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_DEVICE  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_BUS     = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_CMD2,
        ST_POLL,
        ST_CLRSR,
        ST_RESTORE,
        ST_DONE
    } state_e;

    localparam logic [15:0] CMD_ERASE      = 16'h0020;
    localparam logic [15:0] CMD_PROGRAM    = 16'h0040;
    localparam logic [15:0] CMD_CLR_SR     = 16'h0050;
    localparam logic [15:0] CMD_UNLOCK     = 16'h0060;
    localparam logic [15:0] CMD_READ_SR    = 16'h0070;
    localparam logic [15:0] CMD_CONFIRM    = 16'h00D0;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    // Setup word that opens each two-cycle command sequence.
    function automatic logic [15:0] first_cmd(input logic [1:0] op);
        logic [15:0] cmd;
        case (op)
            OP_ERASE:   cmd = CMD_ERASE;
            OP_PROGRAM: cmd = CMD_PROGRAM;
            OP_UNLOCK:  cmd = CMD_UNLOCK;
            default:    cmd = CMD_READ_SR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/bpi_axil_single.sv
// One AXI-lite write or read per start pulse. Ports: start_i/we_i/addr_i/
// wdata_i request, done_o/err_o/rdata_o result, m_axi_* master channels.
module bpi_axil_single #(
    parameter int AW = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic          done_o,
    output logic          err_o,
    output logic [31:0]   rdata_o,
    output logic [AW-1:0] m_axi_awaddr,
    output logic [2:0]    m_axi_awprot,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,
    output logic [31:0]   m_axi_wdata,
    output logic [3:0]    m_axi_wstrb,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,
    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready,
    output logic [AW-1:0] m_axi_araddr,
    output logic [2:0]    m_axi_arprot,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,
    input  logic [31:0]   m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready
);

    logic [AW-1:0] addr_q;
    logic [15:0]   data_q;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          b_hs, r_hs;

    assign b_hs = bready_q & m_axi_bvalid;
    assign r_hs = rready_q & m_axi_rvalid;

    always_comb begin
        awvalid_d = (start_i & we_i) | (awvalid_q & ~m_axi_awready);
        wvalid_d  = (start_i & we_i) | (wvalid_q & ~m_axi_wready);
        arvalid_d = (start_i & ~we_i) | (arvalid_q & ~m_axi_arready);
        rready_d  = (rready_q & ~m_axi_rvalid) | (arvalid_q & m_axi_arready);
        // Response phase opens once the last of AW/W has handshaken.
        bready_d  = (bready_q & ~m_axi_bvalid)
                  | ((awvalid_q | wvalid_q) & ~(awvalid_q & ~m_axi_awready)
                     & ~(wvalid_q & ~m_axi_wready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            if (start_i) begin
                addr_q <= addr_i;
                data_q <= wdata_i;
            end
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_wdata   = {data_q, data_q};
    assign m_axi_wstrb   = addr_q[1] ? 4'b1100 : 4'b0011;

    assign done_o  = b_hs | r_hs;
    assign err_o   = (b_hs & (m_axi_bresp != 2'b00))
                   | (r_hs & (m_axi_rresp != 2'b00));
    assign rdata_o = m_axi_rdata;

endmodule

// File: rtl/bpi_cmd_sequencer.sv
// Runs CFI erase/program/unlock sequences with status polling and read-array
// restore. Ports: req_* request, done_* completion, m_axi_* AXI-lite master.
module bpi_cmd_sequencer
    import bpi_cmd_pkg::*;
#(
    parameter  int C_AXI_WIDTH  = 32,
    parameter  int C_MEM_SIZE   = 134217728,
    parameter  int C_POLL_LIMIT = 16777215,
    localparam int AW           = $clog2(C_MEM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [AW-1:0]          req_addr,
    input  logic [15:0]            req_data,
    output logic                   done_valid,
    output logic [7:0]             done_status,
    output logic [1:0]             done_error,
    output logic [AW-1:0]          m_axi_awaddr,
    output logic [2:0]             m_axi_awprot,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [C_AXI_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]             m_axi_wstrb,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [AW-1:0]          m_axi_araddr,
    output logic [2:0]             m_axi_arprot,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [C_AXI_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);

    localparam int          CW       = $clog2(C_POLL_LIMIT + 1);
    localparam logic [CW-1:0] POLL_MAX = CW'(C_POLL_LIMIT);

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [AW-1:1]  addr_q, addr_d;
    logic [15:0]    data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           eval_q, eval_d;
    logic [7:0]     sr_q, sr_d;
    logic [7:0]     status_q, status_d;
    err_e           err_q, err_d;

    logic           ax_start, ax_we, ax_done, ax_err;
    logic [AW-1:0]  ax_addr;
    logic [15:0]    ax_wdata;
    logic [31:0]    ax_rdata;
    logic           unused_bits;

    assign unused_bits = ^{req_addr[0], ax_rdata[31:24], ax_rdata[15:8]};
    assign cnt_inc = (cnt_q == POLL_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'd0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            eval_q   <= 1'b0;
            sr_q     <= 8'h00;
            status_q <= 8'h00;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            eval_q   <= eval_d;
            sr_q     <= sr_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        eval_d   = eval_q;
        sr_d     = sr_q;
        status_d = status_q;
        err_d    = err_q;
        ax_start = 1'b0;
        ax_we    = 1'b1;
        ax_addr  = {addr_q, 1'b0};
        ax_wdata = CMD_READ_ARRAY;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    status_d = 8'h00;
                    if (req_op == OP_RSVD) begin
                        err_d   = ERR_BUS;
                        state_d = ST_DONE;
                    end else begin
                        err_d    = ERR_OK;
                        op_d     = req_op;
                        addr_d   = req_addr[AW-1:1];
                        data_d   = req_data;
                        cnt_d    = '0;
                        eval_d   = 1'b0;
                        ax_start = 1'b1;
                        ax_addr  = {req_addr[AW-1:1], 1'b0};
                        ax_wdata = first_cmd(req_op);
                        state_d  = ST_CMD1;
                    end
                end
            end
            ST_CMD1: begin
                if (ax_done) begin
                    ax_start = 1'b1;
                    ax_wdata = (op_q == OP_PROGRAM) ? data_q : CMD_CONFIRM;
                    state_d  = ST_CMD2;
                end
            end
            ST_CMD2: begin
                if (ax_done) begin
                    ax_start = 1'b1;
                    ax_we    = 1'b0;
                    cnt_d    = cnt_inc;
                    state_d  = ST_POLL;
                end
            end
            ST_POLL: begin
                // Read data is latched first and judged one cycle later.
                if (eval_q) begin
                    eval_d   = 1'b0;
                    ax_start = 1'b1;
                    if (sr_q[7]) begin
                        status_d = sr_q;
                        if (sr_q[5:1] != 5'd0) begin
                            err_d    = ERR_DEVICE;
                            ax_wdata = CMD_CLR_SR;
                            state_d  = ST_CLRSR;
                        end else begin
                            state_d  = ST_RESTORE;
                        end
                    end else if (cnt_q == POLL_MAX) begin
                        status_d = 8'h00;
                        err_d    = ERR_TIMEOUT;
                        state_d  = ST_RESTORE;
                    end else begin
                        ax_we = 1'b0;
                        cnt_d = cnt_inc;
                    end
                end else if (ax_done) begin
                    sr_d   = addr_q[1] ? ax_rdata[23:16] : ax_rdata[7:0];
                    eval_d = 1'b1;
                end
            end
            ST_CLRSR: begin
                if (ax_done) begin
                    ax_start = 1'b1;
                    state_d  = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                if (ax_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A bus error ends the sequence at once with no further traffic.
        if (ax_done && ax_err) begin
            ax_start = 1'b0;
            eval_d   = 1'b0;
            status_d = 8'h00;
            err_d    = ERR_BUS;
            state_d  = ST_DONE;
        end
    end

    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        done_valid  = (state_q == ST_DONE);
        done_status = status_q;
        done_error  = err_q;
    end

    bpi_axil_single #(.AW(AW)) u_axil (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (ax_start),
        .we_i          (ax_we),
        .addr_i        (ax_addr),
        .wdata_i       (ax_wdata),
        .done_o        (ax_done),
        .err_o         (ax_err),
        .rdata_o       (ax_rdata),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule
